// File: rtl/key_lookup_arbiter_if.sv
// Request channel between the key-lookup arbiter (master) and the shared lookup engine (slave).
// The master presents key/src/valid; the engine answers with ready and a one-cycle done pulse.
interface key_lookup_arbiter_if #(
   parameter int KEY_WIDTH = 32,
   parameter int SRC_WIDTH = 2
);
   logic [KEY_WIDTH-1:0] o_lkp_key;
   logic [SRC_WIDTH-1:0] o_lkp_src;
   logic                 o_lkp_valid;
   logic                 i_lkp_ready;
   logic                 i_lkp_done;

   modport master (output o_lkp_key, o_lkp_src, o_lkp_valid, input i_lkp_ready, i_lkp_done);
   modport slave  (input o_lkp_key, o_lkp_src, o_lkp_valid, output i_lkp_ready, i_lkp_done);
endinterface

// File: rtl/key_lookup_arbiter.sv
// Round-robin arbiter sharing one single-outstanding key-lookup engine among NUM_REQ extractors.
// Optional per-requester drop counters are built when KEY_ARB_STATS_EN is defined.
module key_lookup_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int SRC_WIDTH = 2,
   parameter int KEY_WIDTH = 32,
   parameter int TIMEOUT   = 255
`ifdef KEY_ARB_STATS_EN
   ,parameter int CNT_WIDTH = 16
`endif
) (
   input  logic                         axis_aclk,
   input  logic                         axis_reset,
   input  logic [NUM_REQ*KEY_WIDTH-1:0] i_key,
   input  logic [NUM_REQ-1:0]           i_key_valid,
   key_lookup_arbiter_if.master         lkp,
   output logic [NUM_REQ-1:0]           o_pending,
   output logic                         o_busy,
   output logic                         o_timeout
`ifdef KEY_ARB_STATS_EN
   ,output logic [NUM_REQ*CNT_WIDTH-1:0] o_drop_cnt
`endif
);

   localparam int TMR_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE} state_t;

   state_t               state;
   logic [NUM_REQ-1:0]   pend;
   logic [KEY_WIDTH-1:0] hold [NUM_REQ];
   logic [SRC_WIDTH-1:0] ptr;
   logic [TMR_W-1:0]     timer;
   logic [SRC_WIDTH-1:0] win;
   logic [SRC_WIDTH-1:0] cand;
   logic                 found;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   accept;

   // Search starts one past the last winner so every requester is served in turn.
   always_comb begin
      win   = ptr;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = SRC_WIDTH'((int'(ptr) + k) % NUM_REQ);
         if (!found && pend[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (state == ST_IDLE && found) grant[win] = 1'b1;
   end

   // A slot freed by this cycle's grant may be refilled in the same cycle.
   assign accept = i_key_valid & (~pend | grant);

   always_ff @(posedge axis_aclk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) hold[i] <= i_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
   end

   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) begin
         state           <= ST_IDLE;
         pend            <= '0;
         ptr             <= SRC_WIDTH'(NUM_REQ - 1);
         timer           <= '0;
         o_timeout       <= 1'b0;
         lkp.o_lkp_key   <= '0;
         lkp.o_lkp_src   <= '0;
         lkp.o_lkp_valid <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         pend      <= (pend & ~grant) | accept;
         case (state)
            ST_IDLE: begin
               if (found) begin
                  lkp.o_lkp_key   <= hold[win];
                  lkp.o_lkp_src   <= win;
                  lkp.o_lkp_valid <= 1'b1;
                  ptr             <= win;
                  state           <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (lkp.i_lkp_ready) begin
                  lkp.o_lkp_valid <= 1'b0;
                  timer           <= '0;
                  state           <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               // A done arriving on the last allowed cycle still counts as a completion.
               if (lkp.i_lkp_done) begin
                  state <= ST_IDLE;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  o_timeout <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy    = (state != ST_IDLE);
   assign o_pending = pend;

`ifdef KEY_ARB_STATS_EN
   logic [NUM_REQ-1:0] drop;

   assign drop = i_key_valid & pend & ~grant;

   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) begin
         o_drop_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (drop[i] && (o_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}}))
               o_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= o_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
         end
      end
   end
`else
   // Keys arriving on an occupied slot are discarded without any record.
`endif

endmodule

// File: tb/tb_key_lookup_arbiter.sv
// Randomized scoreboard bench for key_lookup_arbiter: a behavioural model predicts grants,
// timeouts and pending/busy state; a monitor compares them against the DUT each cycle.
module tb_key_lookup_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int SRC_WIDTH = 2;
   localparam int KEY_WIDTH = 32;
   localparam int TIMEOUT   = 8;
   localparam int NCYC      = 3000;
   localparam int PH_IDLE   = 0;
   localparam int PH_ISSUE  = 1;
   localparam int PH_WAIT   = 2;

   logic                         axis_aclk  = 1'b0;
   logic                         axis_reset = 1'b1;
   logic [NUM_REQ*KEY_WIDTH-1:0] key_bus    = '0;
   logic [NUM_REQ-1:0]           key_vld    = '0;
   logic [NUM_REQ-1:0]           pending;
   logic                         busy;
   logic                         tmo;
`ifdef KEY_ARB_STATS_EN
   localparam int CNT_WIDTH = 16;
   logic [NUM_REQ*CNT_WIDTH-1:0] drop_cnt;
`endif

   key_lookup_arbiter_if #(.KEY_WIDTH(KEY_WIDTH), .SRC_WIDTH(SRC_WIDTH)) lkp();

   key_lookup_arbiter #(
      .NUM_REQ(NUM_REQ), .SRC_WIDTH(SRC_WIDTH), .KEY_WIDTH(KEY_WIDTH), .TIMEOUT(TIMEOUT)
`ifdef KEY_ARB_STATS_EN
      ,.CNT_WIDTH(CNT_WIDTH)
`endif
   ) dut (
      .axis_aclk  (axis_aclk),
      .axis_reset (axis_reset),
      .i_key      (key_bus),
      .i_key_valid(key_vld),
      .lkp        (lkp),
      .o_pending  (pending),
      .o_busy     (busy),
      .o_timeout  (tmo)
`ifdef KEY_ARB_STATS_EN
      ,.o_drop_cnt(drop_cnt)
`endif
   );

   always #5 axis_aclk = ~axis_aclk;

   typedef struct { logic [31:0] key; int src; int cyc; } req_t;
   typedef struct { logic [NUM_REQ-1:0] pend; logic busy; int cyc; } st_t;

   req_t req_q[$];
   int   to_q[$];
   st_t  st_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   always @(posedge axis_aclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: pending slots, last-winner pointer and engine phase.
   int          m_phase = PH_IDLE;
   int          m_timer = 0;
   int          m_ptr   = NUM_REQ - 1;
   int          m_d     = 0;
   bit          m_pend  [NUM_REQ];
   logic [31:0] m_hold  [NUM_REQ];
   int          m_drops [NUM_REQ];

   function automatic bit m_any_pend();
      bit r = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) r |= m_pend[i];
      return r;
   endfunction

   task automatic model_step(input bit directed);
      int   clr = -1;
      req_t r;
      st_t  s;
      if (m_phase == PH_IDLE) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (clr < 0 && m_pend[(m_ptr + k) % NUM_REQ]) clr = (m_ptr + k) % NUM_REQ;
         end
         if (clr >= 0) begin
            r.key = m_hold[clr]; r.src = clr; r.cyc = cyc + 1;
            req_q.push_back(r);
            m_pend[clr] = 1'b0;
            m_ptr       = clr;
            m_phase     = PH_ISSUE;
         end
      end else if (m_phase == PH_ISSUE) begin
         if (lkp.i_lkp_ready) begin
            m_phase = PH_WAIT;
            m_timer = 0;
            m_d     = directed ? 0 : int'($urandom_range(0, 10));
         end
      end else begin
         if (lkp.i_lkp_done) m_phase = PH_IDLE;
         else if (m_timer == TIMEOUT - 1) begin
            to_q.push_back(cyc + 1);
            m_phase = PH_IDLE;
         end else m_timer++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (key_vld[i]) begin
            if (!m_pend[i]) begin
               m_pend[i] = 1'b1;
               m_hold[i] = key_bus[i*KEY_WIDTH +: KEY_WIDTH];
            end else m_drops[i]++;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) s.pend[i] = m_pend[i];
      s.busy = (m_phase != PH_IDLE);
      s.cyc  = cyc + 1;
      st_q.push_back(s);
   endtask

   task automatic drive_engine(input bit directed);
      lkp.i_lkp_ready = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (m_phase == PH_WAIT) lkp.i_lkp_done = (m_timer == m_d);
      else                    lkp.i_lkp_done = !directed && ($urandom_range(0, 9) == 0);
   endtask

   // Monitor: samples one time unit after each rising edge.
   logic              prev_valid = 1'b0;
   logic [31:0]       held_key   = '0;
   logic [1:0]        held_src   = '0;
   req_t              me;
   st_t               ms;
   logic              hs;

   always @(posedge axis_aclk) begin
      #1;
      if (mon_en) begin
         hs = prev_valid && lkp.i_lkp_ready;
         if (prev_valid) begin
            if (hs) chk("valid_low_after_handshake", 64'(lkp.o_lkp_valid), 64'd0);
            else begin
               chk("valid_held", 64'(lkp.o_lkp_valid), 64'd1);
               chk("key_held", 64'(lkp.o_lkp_key), 64'(held_key));
               chk("src_held", 64'(lkp.o_lkp_src), 64'(held_src));
            end
         end else if (lkp.o_lkp_valid) begin
            if (req_q.size() == 0) chk("unexpected_request", 64'd1, 64'd0);
            else begin
               me = req_q.pop_front();
               chk("req_cycle", 64'(cyc), 64'(me.cyc));
               chk("req_src", 64'(lkp.o_lkp_src), 64'(me.src));
               chk("req_key", 64'(lkp.o_lkp_key), 64'(me.key));
            end
            held_key = lkp.o_lkp_key;
            held_src = lkp.o_lkp_src;
         end
         if (tmo) begin
            if (to_q.size() == 0) chk("unexpected_timeout", 64'd1, 64'd0);
            else chk("timeout_cycle", 64'(cyc), 64'(to_q.pop_front()));
         end
         while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
            me = req_q.pop_front();
            chk("missing_request_src", 64'd255, 64'(me.src));
         end
         while (to_q.size() > 0 && to_q[0] < cyc) begin
            chk("missing_timeout_cycle", 64'(cyc), 64'(to_q.pop_front()));
         end
         while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            ms = st_q.pop_front();
            if (ms.cyc == cyc) begin
               chk("pending", 64'(pending), 64'(ms.pend));
               chk("busy", 64'(busy), 64'(ms.busy));
            end
         end
         prev_valid = lkp.o_lkp_valid;
      end
   end

   initial begin
      bit dir;
      bit reached;
      lkp.i_lkp_ready = 1'b0;
      lkp.i_lkp_done  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         m_pend[i] = 1'b0; m_hold[i] = '0; m_drops[i] = 0;
      end

      repeat (2) @(posedge axis_aclk);
      #1;
      chk("rst_valid", 64'(lkp.o_lkp_valid), 64'd0);
      chk("rst_key", 64'(lkp.o_lkp_key), 64'd0);
      chk("rst_src", 64'(lkp.o_lkp_src), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_timeout", 64'(tmo), 64'd0);
`ifdef KEY_ARB_STATS_EN
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
      @(negedge axis_aclk);
      axis_reset = 1'b0;
      mon_en     = 1'b1;

      for (int c = 0; c < NCYC; c++) begin
         @(negedge axis_aclk);
         dir     = (c < 50);
         key_vld = '0;
         if (dir) begin
            if (c == 0) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  key_vld[i] = 1'b1;
                  key_bus[i*KEY_WIDTH +: KEY_WIDTH] = 32'h100 + i;
               end
            end
            if (c == 20) begin
               key_vld[0] = 1'b1; key_bus[0*KEY_WIDTH +: KEY_WIDTH] = 32'h200;
               key_vld[3] = 1'b1; key_bus[3*KEY_WIDTH +: KEY_WIDTH] = 32'h203;
            end
            if (c == 35) begin
               key_vld[1] = 1'b1; key_bus[1*KEY_WIDTH +: KEY_WIDTH] = 32'hA5A5_0001;
            end
         end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  key_vld[i] = 1'b1;
                  key_bus[i*KEY_WIDTH +: KEY_WIDTH] = $urandom;
               end
            end
         end
         drive_engine(dir);
         model_step(dir);
      end

      key_vld = '0;
      for (int k = 0; k < 200; k++) begin
         @(negedge axis_aclk);
         drive_engine(1'b0);
         model_step(1'b0);
         if (m_phase == PH_IDLE && !m_any_pend()) break;
      end
      repeat (3) @(posedge axis_aclk);
      #2;
      chk("request_queue_drained", 64'(req_q.size()), 64'd0);
      chk("timeout_queue_drained", 64'(to_q.size()), 64'd0);
`ifdef KEY_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++)
         chk("drop_cnt", 64'(drop_cnt[i*CNT_WIDTH +: CNT_WIDTH]), 64'((m_drops[i] > 65535) ? 65535 : m_drops[i]));
`endif

      // Asynchronous reset while a lookup is outstanding.
      mon_en = 1'b0;
      @(negedge axis_aclk);
      key_vld = 4'b0100;
      key_bus[2*KEY_WIDTH +: KEY_WIDTH] = 32'hDEAD_0002;
      lkp.i_lkp_ready = 1'b1;
      lkp.i_lkp_done  = 1'b0;
      @(negedge axis_aclk);
      key_vld = '0;
      reached = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge axis_aclk);
         #1;
         if (busy && !lkp.o_lkp_valid) begin
            reached = 1'b1;
            break;
         end
      end
      chk("reach_wait_done", 64'(reached), 64'd1);
      chk("wait_src", 64'(lkp.o_lkp_src), 64'd2);
      #2;
      axis_reset = 1'b1;
      #1;
      chk("arst_valid", 64'(lkp.o_lkp_valid), 64'd0);
      chk("arst_key", 64'(lkp.o_lkp_key), 64'd0);
      chk("arst_src", 64'(lkp.o_lkp_src), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_pending", 64'(pending), 64'd0);
      for (int k = 0; k < TIMEOUT + 2; k++) begin
         @(posedge axis_aclk);
         #1;
         chk("no_timeout_in_reset", 64'(tmo), 64'd0);
      end
      @(negedge axis_aclk);
      axis_reset = 1'b0;
      repeat (2) @(posedge axis_aclk);
      #1;
      chk("post_reset_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
